// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: FIFO-buffered I2S / left-justified / TDM serial audio transmitter
module audio_i2s_tx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int NCH        = 2,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode,
    input  logic [NCH*DATA_W-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);
    localparam int TOT = NCH * SLOT_W;
    localparam int FW  = NCH * DATA_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PW  = $clog2(TOT);
    localparam int DW  = $clog2(BCLK_DIV);

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] cur, nxt_frame, fr;
    logic [DW-1:0] div;
    logic [PW-1:0] per;
    logic          running, mode_r, m;
    logic          push, pop, period_end, frame_start, bit_event;
    logic          sd_next, lr_next;
    int            np;

    // Bit of the left-justified stream at period p: DATA_W sample bits MSB first, then zero pad
    function automatic logic slot_bit(input logic [FW-1:0] f, input int p);
        int s, b;
        s = p / SLOT_W;
        b = p % SLOT_W;
        if (b >= DATA_W) return 1'b0;
        return f[s*DATA_W + DATA_W - 1 - b];
    endfunction

    assign in_ready    = fifo_level != LW'(FIFO_DEPTH);
    assign push        = in_valid && in_ready;
    assign period_end  = running && (int'(div) == BCLK_DIV - 1);
    assign frame_start = enable && (!running || (period_end && int'(per) == TOT - 1));
    assign bit_event   = frame_start || (enable && period_end);
    assign pop         = frame_start && (fifo_level != '0);
    assign np          = frame_start ? 0 : int'(per) + 1;
    assign bclk        = running && (int'(div) >= BCLK_DIV / 2);

    // Next sdata/lrck values for the bit period about to begin; I2S mode lags one period
    always_comb begin
        nxt_frame = pop ? mem[rd_ptr] : '0;
        fr        = frame_start ? nxt_frame : cur;
        m         = frame_start ? mode : mode_r;
        sd_next   = m ? slot_bit(fr, np) : (np == 0 ? slot_bit(cur, TOT - 1) : slot_bit(fr, np - 1));
        lr_next   = (NCH == 2) ? (np >= SLOT_W) : (m ? (np == 0) : (np == TOT - 1));
    end

    // Bit-clock divider, period counter and serial output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            div     <= '0;
            per     <= '0;
            cur     <= '0;
            mode_r  <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
        end else if (!enable) begin
            running <= 1'b0;
            div     <= '0;
            per     <= '0;
            cur     <= '0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
        end else begin
            running <= 1'b1;
            div     <= (frame_start || period_end) ? '0 : div + 1'b1;
            if (bit_event) begin
                per   <= PW'(np);
                lrck  <= lr_next;
                sdata <= sd_next;
            end
            if (frame_start) begin
                cur    <= nxt_frame;
                mode_r <= mode;
            end
        end
    end

    // FIFO pointers, occupancy and sticky underrun (set wins over clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (frame_start && fifo_level == '0) underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed tests for audio_i2s_tx (stereo default instance plus a 4-channel TDM instance)
module tb_audio_i2s_tx;
    logic        clk = 0, rst = 1;
    logic        enable = 0, mode = 0, in_valid = 0, underrun_clr = 0;
    logic [47:0] in_data = '0;
    logic        in_ready, bclk, lrck, sdata, underrun;
    logic [3:0]  fifo_level;

    logic        t_enable = 0, t_mode = 1, t_valid = 0, t_clr = 0;
    logic [95:0] t_data = '0;
    logic        t_ready, t_bclk, t_lrck, t_sdata, t_underrun;
    logic [3:0]  t_level;

    int tests = 0, fails = 0;

    audio_i2s_tx dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrck(lrck), .sdata(sdata),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    audio_i2s_tx #(.NCH(4)) tdm (
        .clk(clk), .rst(rst), .enable(t_enable), .mode(t_mode), .in_data(t_data),
        .in_valid(t_valid), .in_ready(t_ready), .bclk(t_bclk), .lrck(t_lrck), .sdata(t_sdata),
        .fifo_level(t_level), .underrun(t_underrun), .underrun_clr(t_clr)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        in_valid = 1;
        in_data  = {r, l};
        @(negedge clk);
        in_valid = 0;
    endtask

    // Runs one stereo frame from enable, sampling on each bclk high phase, then disables before the next frame
    task automatic capture(output logic [63:0] sd, output logic [63:0] lr);
        logic bad;
        bad = 0;
        @(negedge clk);
        enable = 1;
        @(posedge clk);
        for (int k = 0; k < 64; k++) begin
            repeat (2) @(posedge clk);
            #1;
            sd[63-k] = sdata;
            lr[63-k] = lrck;
            if (!bclk) bad = 1;
            if (k < 63) repeat (2) @(posedge clk);
        end
        @(negedge clk);
        enable = 0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bclk_phase: got bclk=0 at a sample point, expected 1");
        end
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if ({bclk, lrck, sdata, underrun} !== 4'b0000 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got bclk%b lrck%b sdata%b ur%b lvl%0d rdy%b, expected 0 0 0 0 0 1",
                     bclk, lrck, sdata, underrun, fifo_level, in_ready);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_left_justified;
        logic [63:0] sd, lr;
        mode = 1;
        push_frame(24'h800001, 24'h7FFFFE);
        tests++;
        if (fifo_level !== 4'd1) begin fails++; $display("FAIL lj_level_before: got %0d expected 1", fifo_level); end
        capture(sd, lr);
        tests++;
        if (sd !== 64'h80000100_7FFFFE00) begin fails++; $display("FAIL lj_sdata: got %h expected %h", sd, 64'h80000100_7FFFFE00); end
        tests++;
        if (lr !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL lj_lrck: got %h expected %h", lr, 64'h00000000_FFFFFFFF); end
        tests++;
        if (fifo_level !== 4'd0 || underrun !== 1'b0) begin
            fails++; $display("FAIL lj_after: got lvl %0d ur %b expected 0 0", fifo_level, underrun);
        end
    endtask

    task automatic test_i2s;
        logic [63:0] sd, lr;
        mode = 0;
        push_frame(24'h800001, 24'h7FFFFE);
        capture(sd, lr);
        tests++;
        if (sd !== 64'h40000080_3FFFFF00) begin fails++; $display("FAIL i2s_sdata: got %h expected %h", sd, 64'h40000080_3FFFFF00); end
        tests++;
        if (lr !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL i2s_lrck: got %h expected %h", lr, 64'h00000000_FFFFFFFF); end
        mode = 1;
    endtask

    task automatic test_fifo_full;
        logic [63:0] sd, lr;
        logic [23:0] l, r;
        @(negedge clk);
        in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            in_data = {24'h050000 + 24'(i), 24'hA00000 + 24'(i)};
            @(negedge clk);
        end
        in_valid = 0;
        tests++;
        if (in_ready !== 1'b0 || fifo_level !== 4'd8) begin
            fails++; $display("FAIL full: got rdy %b lvl %0d expected 0 8", in_ready, fifo_level);
        end
        for (int i = 0; i < 8; i++) begin
            l = 24'hA00000 + 24'(i);
            r = 24'h050000 + 24'(i);
            capture(sd, lr);
            tests++;
            if (sd !== {l, 8'h00, r, 8'h00}) begin
                fails++; $display("FAIL order_%0d: got %h expected %h", i, sd, {l, 8'h00, r, 8'h00});
            end
        end
        tests++;
        if (fifo_level !== 4'd0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL drained: got lvl %0d ur %b rdy %b expected 0 0 1", fifo_level, underrun, in_ready);
        end
    endtask

    task automatic test_underrun;
        logic [63:0] sd, lr;
        capture(sd, lr);
        tests++;
        if (sd !== 64'd0) begin fails++; $display("FAIL ur_sdata: got %h expected 0", sd); end
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set: got %b expected 1", underrun); end
        @(negedge clk);
        underrun_clr = 1;
        @(negedge clk);
        underrun_clr = 0;
        tests++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clr: got %b expected 0", underrun); end
        capture(sd, lr);
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL ur_reassert: got %b expected 1", underrun); end
        @(negedge clk);
        underrun_clr = 1;
        @(negedge clk);
        underrun_clr = 0;
    endtask

    task automatic test_tdm;
        logic [127:0] sd, lr;
        logic bad;
        bad = 0;
        @(negedge clk);
        t_valid = 1;
        t_data  = {24'hABCDEF, 24'h00F003, 24'h0F0002, 24'hF00001};
        @(negedge clk);
        t_valid = 0;
        t_enable = 1;
        @(posedge clk);
        for (int k = 0; k < 128; k++) begin
            repeat (2) @(posedge clk);
            #1;
            sd[127-k] = t_sdata;
            lr[127-k] = t_lrck;
            if (!t_bclk) bad = 1;
            if (k < 127) repeat (2) @(posedge clk);
        end
        @(negedge clk);
        t_enable = 0;
        tests++;
        if (sd !== {24'hF00001, 8'h00, 24'h0F0002, 8'h00, 24'h00F003, 8'h00, 24'hABCDEF, 8'h00}) begin
            fails++; $display("FAIL tdm_sdata: got %h", sd);
        end
        tests++;
        if (lr !== {1'b1, 127'd0}) begin fails++; $display("FAIL tdm_lrck: got %h expected %h", lr, {1'b1, 127'd0}); end
        tests++;
        if (bad || t_level !== 4'd0 || t_underrun !== 1'b0) begin
            fails++; $display("FAIL tdm_misc: got bclk_bad %b lvl %0d ur %b expected 0 0 0", bad, t_level, t_underrun);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) push_frame(24'hFFFFFF, 24'hFFFFFF);
        @(negedge clk);
        enable = 1;
        @(posedge clk);
        repeat (42) @(posedge clk);
        #2;
        tests++;
        if (bclk !== 1'b1 || sdata !== 1'b1 || fifo_level !== 4'd2) begin
            fails++; $display("FAIL pre_reset: got bclk %b sdata %b lvl %0d expected 1 1 2", bclk, sdata, fifo_level);
        end
        rst = 1;
        #1;
        tests++;
        if ({bclk, lrck, sdata} !== 3'b000 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset: got bclk%b lrck%b sdata%b lvl%0d rdy%b expected 0 0 0 0 1",
                              bclk, lrck, sdata, fifo_level, in_ready);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        tests++;
        if (underrun !== 1'b1 || fifo_level !== 4'd0) begin
            fails++; $display("FAIL post_reset_underrun: got ur %b lvl %0d expected 1 0", underrun, fifo_level);
        end
        @(negedge clk);
        enable = 0;
    endtask

    initial begin
        test_reset;
        test_left_justified;
        test_i2s;
        test_fifo_full;
        test_underrun;
        test_tdm;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
